fe_flush_ctrl: RTL
==================

// Module: fe_flush_ctrl
// PURPOSE
//  Sequencer for front-end flush and redirect. It sits between the decode, mem/wb and branch-check logic and the fetch/decode pipe register.
//  Arbitrates four flush sources: exception, interrupt, branch-predict error and FENCE/FENCE.I.
//  Drives fet_flush, fence_stall, a single redirect PC to fetch, and the icache invalidate handshake for FENCE.I.
//  Holds fence_stall across the fence drain, so the PC stalls while the following pipe is flushed.
// PARAMETERS
//  DRAIN_CYC  3   non-stalled cycles needed for the instrs ahead of a fence to leave ex/mem/wb
//  PC_W       32  PC width
// PORTS
//  clk           in   1     clock, rising edge
//  cpurst        in   1     reset; synchronous, active-high
//  de_stall      in   1     decode stall
//  exe_stall     in   1     execute stall
//  memacc_stall  in   1     memory-access stall; stall = de_stall|exe_stall|memacc_stall
//  exp_req       in   1     exception retiring at mem/wb (mem2wb_exp_ffout)
//  exp_pc        in   PC_W  trap vector
//  int_req       in   1     pending enabled interrupt (level)
//  int_pc        in   PC_W  interrupt vector
//  bp_err        in   1     branch mispredict resolved
//  bp_pc         in   PC_W  corrected target
//  fence_req     in   1     FENCE/FENCE.I valid in decode
//  fence_i       in   1     qualifies fence_req as FENCE.I
//  fence_nxt_pc  in   PC_W  PC of instr after the fence
//  wbuf_empty    in   1     store/write buffer empty
//  inv_done      in   1     icache invalidate complete (pulse)
//  fet_flush     out  1     flush fetch/decode register (1-cycle pulse)
//  fence_stall   out  1     hold PC, insert NOPs behind fence
//  redir_valid   out  1     load redir_pc into fetch PC (1-cycle pulse)
//  redir_pc      out  PC_W  redirect target
//  icache_inv    out  1     icache invalidate request (level until inv_done)
//  busy          out  1     FSM not IDLE
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; all outputs 0, including redir_pc=0. Reset overrides any state, mid-fence included, in the same edge.
//  Latency: an event sampled at edge N gives a registered redirect at N+1, where fet_flush=redir_valid=1 for exactly one cycle.
//  Sampling rule: bp_err, int_req and fence_req are accepted only in IDLE with stall=0.
//   exp_req is accepted in any state regardless of stall; an exception is never lost.
//  Priority, when events coincide: exp_req > int_req > bp_err > fence_req.
//   A lower-priority event that loses is dropped; its source re-presents it or it is squashed by the flush.
//  States:
//   IDLE:  exp/int/bp accepted -> pulse redirect with exp_pc/int_pc/bp_pc; stay IDLE.
//          fence accepted -> latch fence_i and fence_nxt_pc; cnt=DRAIN_CYC; go to DRAIN.
//   DRAIN: fence_stall=1; cnt decrements on cycles with stall=0 and saturates at 0.
//          cnt==0 & wbuf_empty -> INV if fence_i, else REDIR.
//   INV:   fence_stall=1, icache_inv=1; inv_done -> REDIR. inv_done outside INV is ignored.
//   REDIR: fence_stall=1 for this cycle; next edge pulses redirect with the latched fence_nxt_pc -> IDLE.
//  exp_req in DRAIN/INV/REDIR aborts the fence: icache_inv and fence_stall drop at next edge; exp redirect pulses; -> IDLE.
//  int_req and bp_err outside IDLE are ignored. int_req is level and is taken after the fence completes.
//  busy = (state!=IDLE). fence_stall is registered, i.e. high from the edge after fence acceptance.
//  Back-to-back fences: the fence re-presented in IDLE after REDIR is a new fence; no merging.
//  DRAIN_CYC=0: DRAIN exits on its first cycle once wbuf_empty=1.
// STRUCTURE
//  Shared package fe_pkg:
//   state localparams IDLE=2'd0, DRAIN=2'd1, INV=2'd2, REDIR=2'd3
//   cause codes used for debug: CS_EXP, CS_INT, CS_BP, CS_FENCE
//  Sub-module fe_flush_arb: combinational fixed-priority picker (req vector -> one-hot grant + selected PC). Reused by the future LSU replay controller.
//  Counter and FSM stay inline.
// TESTING
//  1 bp_err=1, bp_pc=0x100, stall=0 at edge N -> fet_flush=redir_valid=1, redir_pc=0x100 at N+1 only; busy=0.
//  2 bp_err=1 with exe_stall=1 for 3 cycles -> no output; after stall drops, still no redirect unless bp_err is still high.
//  3 FENCE, nxt_pc=0x204, fence_i=0, stall=0, wbuf_empty=1 -> fence_stall high 4 cycles (3 DRAIN, 1 REDIR); then redirect to 0x204.
//  4 FENCE.I, wbuf_empty low 5 cycles, inv_done 2 cycles after INV entry -> icache_inv high exactly until inv_done; then redirect.
//  5 exp_req, exp_pc=0x80, during INV -> icache_inv=0, fence_stall=0, redirect 0x80 at next edge; state IDLE.
//  6 exp_req+int_req+bp_err same cycle -> redir_pc=exp_pc; then cpurst in DRAIN -> all outputs 0 at next edge.

Source files
------------

// File: rtl/fe_pkg.sv
// fe_pkg: shared state and cause encodings for the front-end flush sequencer
package fe_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, INV = 2'd2, REDIR = 2'd3} fe_state_t;
  typedef enum logic [1:0] {CS_EXP = 2'd0, CS_INT = 2'd1, CS_BP = 2'd2, CS_FENCE = 2'd3} fe_cause_t;
  localparam int unsigned NUM_CS = 4;
endpackage

// File: rtl/fe_flush_arb.sv
// fe_flush_arb: fixed-priority picker, bit 0 highest, one-hot grant plus selected pc
module fe_flush_arb #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] pc_in,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   pc
);
  always_comb begin
    gnt = '0;
    pc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt = '0;
        gnt[i] = 1'b1;
        pc = pc_in[i*W +: W];
      end
    end
  end
endmodule

// File: rtl/fe_flush_ctrl.sv
// fe_flush_ctrl: arbitrates exception/interrupt/mispredict/fence flushes and sequences fence drain and icache invalidate
module fe_flush_ctrl
  import fe_pkg::*;
#(
  parameter int DRAIN_CYC = 3,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            cpurst,
  input  logic            de_stall,
  input  logic            exe_stall,
  input  logic            memacc_stall,
  input  logic            exp_req,
  input  logic [PC_W-1:0] exp_pc,
  input  logic            int_req,
  input  logic [PC_W-1:0] int_pc,
  input  logic            bp_err,
  input  logic [PC_W-1:0] bp_pc,
  input  logic            fence_req,
  input  logic            fence_i,
  input  logic [PC_W-1:0] fence_nxt_pc,
  input  logic            wbuf_empty,
  input  logic            inv_done,
  output logic            fet_flush,
  output logic            fence_stall,
  output logic            redir_valid,
  output logic [PC_W-1:0] redir_pc,
  output logic            icache_inv,
  output logic            busy
);
  localparam int CW = $clog2(DRAIN_CYC + 2);
  fe_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
  logic fi_q, fi_d, rv_q, rv_d, fs_q, fs_d, inv_q, inv_d;
  logic [PC_W-1:0] fpc_q, fpc_d, pc_q, pc_d, arb_pc;
  logic [NUM_CS-1:0] req, gnt;
  logic stall, take;
  assign stall = de_stall | exe_stall | memacc_stall;
  assign take = (state_q == IDLE) & ~stall;
  assign req[CS_EXP] = exp_req;
  assign req[CS_INT] = int_req & take;
  assign req[CS_BP] = bp_err & take;
  assign req[CS_FENCE] = fence_req & take;
  fe_flush_arb #(.N(NUM_CS), .W(PC_W)) u_arb (
    .req   (req),
    .pc_in ({fence_nxt_pc, bp_pc, int_pc, exp_pc}),
    .gnt   (gnt),
    .pc    (arb_pc)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    fi_d = fi_q;
    fpc_d = fpc_q;
    rv_d = 1'b0;
    pc_d = pc_q;
    cnt_nx = (!stall && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    case (state_q)
      IDLE: if (gnt[CS_FENCE]) begin
        fi_d = fence_i;
        fpc_d = fence_nxt_pc;
        cnt_d = CW'(DRAIN_CYC);
        state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_nx;
        if (cnt_nx == '0 && wbuf_empty) state_d = fi_q ? INV : REDIR;
      end
      INV: if (inv_done) state_d = REDIR;
      default: begin
        state_d = IDLE;
        rv_d = 1'b1;
        pc_d = fpc_q;
      end
    endcase
    if (|gnt[2:0]) begin
      state_d = IDLE;
      rv_d = 1'b1;
      pc_d = arb_pc;
    end
    fs_d = state_d != IDLE;
    inv_d = state_d == INV;
  end
  always_ff @(posedge clk) begin
    if (cpurst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      fi_q <= 1'b0;
      fpc_q <= '0;
      rv_q <= 1'b0;
      pc_q <= '0;
      fs_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fi_q <= fi_d;
      fpc_q <= fpc_d;
      rv_q <= rv_d;
      pc_q <= pc_d;
      fs_q <= fs_d;
      inv_q <= inv_d;
    end
  end
  assign fet_flush = rv_q;
  assign redir_valid = rv_q;
  assign redir_pc = pc_q;
  assign fence_stall = fs_q;
  assign icache_inv = inv_q;
  assign busy = state_q != IDLE;
endmodule
